// File: rtl/sipo_collector.sv
// sipo_collector: receives framed serial bits (start, 8 data bits MSB-first,
// even parity) and presents each word on a single-entry valid/ready slot.
// Errors are reported per word (perr) and as a sticky overrun flag (ovr).
module sipo_collector (
    input  logic       c,
    input  logic       rst_n,
    input  logic       sin,
    input  logic       sin_en,
    output logic [7:0] dout,
    output logic       dvalid,
    input  logic       dready,
    output logic       perr,
    output logic       ovr,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_dout;
    logic        r_dvalid;
    logic        r_perr;
    logic        r_ovr;

    logic        w_complete;
    logic        w_par_bad;
    logic        w_handshake;
    logic        w_slot_free;

    // The parity bit is being taken on this edge: the frame is complete.
    assign w_complete  = (r_state == ST_PAR) && sin_en;
    // Even parity: data bits XOR parity bit must be 0 for a good word.
    assign w_par_bad   = ^{r_shift, sin};
    assign w_handshake = r_dvalid && dready;
    // The slot can take a new word if empty or being consumed this cycle.
    assign w_slot_free = !r_dvalid || dready;

    // Frame receiver FSM: walks start -> 8 data bits -> parity, advancing only
    // on qualified bit times so sin_en=0 freezes it in any state.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_shift <= 8'h00;
        end else if (sin_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (sin) begin
                        r_state <= ST_DATA;
                        r_cnt   <= 3'd0;
                    end
                end
                ST_DATA: begin
                    r_shift <= {r_shift[6:0], sin};
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_PAR;
                    end
                end
                ST_PAR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output slot: loads completed words, drains on handshake, and flags a
    // word that arrives while the slot is full and not being consumed.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= 8'h00;
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (w_complete) begin
            if (w_slot_free) begin
                r_dout   <= r_shift;
                r_dvalid <= 1'b1;
                r_perr   <= w_par_bad;
            end else begin
                r_ovr    <= 1'b1;
            end
        end else if (w_handshake) begin
            // dout deliberately holds its last value after consumption.
            r_dvalid <= 1'b0;
            r_perr   <= 1'b0;
        end
    end

    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign perr   = r_perr;
    assign ovr    = r_ovr;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: doc/sipo_collector.md
SIPO_COLLECTOR -- requirements
Module: sipo_collector

Interface
REQ-001 The block SHALL have port c, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port sin, input, 1 bit: serial data bit, MSB-first, driven from the upstream shift register's q[3].
REQ-004 The block SHALL have port sin_en, input, 1 bit: qualifies sin; bits SHALL be sampled only on cycles where sin_en=1.
REQ-005 The block SHALL have port dout, output, 8 bits: assembled data word.
REQ-006 The block SHALL have port dvalid, output, 1 bit: dout holds an unconsumed word.
REQ-007 The block SHALL have port dready, input, 1 bit: consumer accepts dout on a cycle where dvalid=1 and dready=1.
REQ-008 The block SHALL have port perr, output, 1 bit: parity error flag for the word currently in dout.
REQ-009 The block SHALL have port ovr, output, 1 bit: sticky overrun flag.
REQ-010 The block SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be: start bit (1), then 8 data bits MSB-first, then 1 even-parity bit; only sin_en=1 cycles count as bit times.
REQ-012 The FSM SHALL have exactly three states: IDLE, DATA, PAR.
REQ-013 In IDLE, sin_en=1 with sin=1 SHALL move the FSM to DATA and clear the bit counter to 0; sin_en=1 with sin=0 SHALL leave it in IDLE.
REQ-014 In DATA, each sin_en=1 cycle SHALL shift sin into the LSB of an internal 8-bit shift register and increment a 3-bit counter.
REQ-015 When the 8th data bit is taken (counter wraps 7->0), the FSM SHALL move to PAR.
REQ-016 In PAR, the next sin_en=1 cycle SHALL take the parity bit and return the FSM to IDLE.
REQ-017 Parity SHALL be good when the XOR of the 8 data bits and the parity bit equals 0.
REQ-018 Completion (parity bit taken) with the output slot empty SHALL load dout, set dvalid=1, and set perr=parity-bad on the same edge, giving 1-cycle latency from the parity-bit edge to dvalid.
REQ-019 Completion with dvalid=1 and dready=0 SHALL drop the new word, set ovr=1, and leave dout, dvalid and perr unchanged.
REQ-020 Completion on a cycle where dvalid=1 and dready=1 SHALL load the new word (no overrun), and dvalid SHALL stay 1.
REQ-021 A handshake (dvalid=1 and dready=1) without completion SHALL clear dvalid and perr on the next edge; dout SHALL hold its last value.
REQ-022 dready while dvalid=0 SHALL have no effect.
REQ-023 ovr SHALL be sticky and cleared only by reset.
REQ-024 sin_en=0 SHALL freeze the FSM, the counter and the shift register indefinitely in any state.
REQ-025 The output slot SHALL drain independently of the FSM: dvalid and dready SHALL act in all states.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force state to IDLE, counter to 0, shift register to 0, dout=8'h00, dvalid=0, perr=0, ovr=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; a frame SHALL begin only on a start bit after rst_n returns to 1.
REQ-028 Release of rst_n SHALL take effect at the first rising edge of c while rst_n=1.

Verification
REQ-029 Bench SHALL cover single frame: start, data 8'hA5, parity 0, sin_en held 1, dready=0 -> dvalid=1 with dout=8'hA5 and perr=0 one edge after the parity bit.
REQ-030 Bench SHALL cover bad parity: frame with data 8'h01 and parity 0 -> dout=8'h01, perr=1; after dready=1 for one cycle -> dvalid=0, perr=0.
REQ-031 Bench SHALL cover overrun: two frames (8'h3C, then 8'hC3) with dready=0 -> dout stays 8'h3C, ovr=1.
REQ-032 Bench SHALL cover simultaneous events: dready=1 on the parity-bit cycle of a second frame (8'h5A) -> dout=8'h5A, dvalid=1, ovr=0.
REQ-033 Bench SHALL cover gapped sin_en: frame 8'hF0 with sin_en=1 only every 3rd cycle -> dout=8'hF0 and busy=1 throughout the frame.
REQ-034 Bench SHALL cover reset mid-frame: rst_n=0 after 4 data bits -> all outputs at reset values before the next edge; a following complete frame 8'h0F -> dout=8'h0F.
